// File: rtl/vga_pio_plot_bridge.sv
// Turns writeEn rising edges on the HPS PIO word into clipped, addressed plot
// commands, queued in a first-word-fall-through FIFO for the VGA adapter.
module vga_pio_plot_bridge #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [21:0]              pio_word,
    output logic                     vga_mode,
    output logic                     plot_valid,
    input  logic                     plot_ready,
    output logic [8:0]               plot_x,
    output logic [7:0]               plot_y,
    output logic [2:0]               plot_colour,
    output logic [16:0]              plot_addr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         clip_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  colour;
        logic [16:0] addr;
    } entry_t;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t          state, state_next;
    logic [21:0]     s1;
    logic            prev_we;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_idx;
    entry_t          mem [DEPTH];
    entry_t          new_entry, head;

    logic            req, flush, in_range, full, push, pop;
    logic [16:0]     x_ext, y_ext, addr;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1       <= '0;
            prev_we  <= 1'b0;
            vga_mode <= 1'b0;
        end else begin
            s1       <= pio_word;
            prev_we  <= s1[20];
            vga_mode <= s1[21];
        end
    end

    always_comb begin
        req      = s1[20] && !prev_we;
        flush    = (s1[21] != vga_mode);
        x_ext    = 17'(s1[19:11]);
        y_ext    = 17'(s1[10:3]);
        if (s1[21]) begin
            in_range = (s1[19:11] < 9'd320) && (s1[10:3] < 8'd240);
            addr     = (y_ext << 8) + (y_ext << 6) + x_ext;
        end else begin
            in_range = (s1[19:11] < 9'd160) && (s1[10:3] < 8'd120);
            addr     = (y_ext << 7) + (y_ext << 5) + x_ext;
        end
        new_entry = '{x: s1[19:11], y: s1[10:3], colour: s1[2:0], addr: addr};
        full      = (count == CW'(DEPTH));
        // A flush empties the FIFO in the same edge, so it never blocks the new request.
        push      = req && in_range && (flush || !full);
        pop       = (state == HOLD) && plot_ready && !flush;
        wr_idx    = flush ? '0 : wr_ptr;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_idx] <= new_entry;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clip_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (req && !in_range && clip_cnt != '1)
                clip_cnt <= clip_cnt + CNT_W'(1);
            if (req && in_range && !flush && full && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = push ? HOLD : EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) state_next = HOLD;
                HOLD:  if (pop && !push && count == CW'(1)) state_next = EMPTY;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        plot_valid  = (state == HOLD);
        plot_x      = plot_valid ? head.x      : '0;
        plot_y      = plot_valid ? head.y      : '0;
        plot_colour = plot_valid ? head.colour : '0;
        plot_addr   = plot_valid ? head.addr   : '0;
        fifo_count  = count;
    end

endmodule

// File: tb/tb_vga_pio_plot_bridge.sv
// Directed bench for vga_pio_plot_bridge; a queue of expected plots is filled
// as requests are issued and drained as the adapter handshake completes.
module tb_vga_pio_plot_bridge;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [21:0] pio_word;
    logic        vga_mode;
    logic        plot_valid;
    logic        plot_ready;
    logic [8:0]  plot_x;
    logic [7:0]  plot_y;
    logic [2:0]  plot_colour;
    logic [16:0] plot_addr;
    logic [3:0]  fifo_count;
    logic [7:0]  clip_cnt;
    logic [7:0]  drop_cnt;

    vga_pio_plot_bridge #(.DEPTH(8), .CNT_W(8)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .pio_word   (pio_word),
        .vga_mode   (vga_mode),
        .plot_valid (plot_valid),
        .plot_ready (plot_ready),
        .plot_x     (plot_x),
        .plot_y     (plot_y),
        .plot_colour(plot_colour),
        .plot_addr  (plot_addr),
        .fifo_count (fifo_count),
        .clip_cnt   (clip_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x;
        int y;
        int c;
        int addr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;
    int   exp_clip = 0;
    int   exp_drop = 0;
    int   p0;
    bit   cur_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    endtask

    // A handshake seen here completes on the coming rising edge.
    task automatic monitor();
        exp_t e;
        if (plot_valid === 1'b1 && plot_ready === 1'b1) begin
            n_pops++;
            n_checks++;
            assert (q.size() != 0) n_pass++;
            else $error("FAIL unexpected_plot: observed plot with addr %0d, expected none", plot_addr);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("head_addr",   32'(plot_addr),   e.addr);
                chk("head_x",      32'(plot_x),      e.x);
                chk("head_y",      32'(plot_y),      e.y);
                chk("head_colour", 32'(plot_colour), e.c);
            end
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    function automatic bit ref_ok(input bit m, input int x, input int y);
        return m ? (x < 320 && y < 240) : (x < 160 && y < 120);
    endfunction

    task automatic expect_plot(input bit m, input int x, input int y, input int c);
        exp_t e;
        if (m != cur_mode) begin
            q.delete();
            cur_mode = m;
        end
        if (!ref_ok(m, x, y)) begin
            exp_clip++;
        end else if (q.size() >= 8) begin
            exp_drop++;
        end else begin
            e.x = x; e.y = y; e.c = c;
            e.addr = m ? (y * 320 + x) : (y * 160 + x);
            q.push_back(e);
        end
    endtask

    task automatic plot(input bit m, input int x, input int y, input int c);
        expect_plot(m, x, y, c);
        pio_word = {m, 1'b1, 9'(x), 8'(y), 3'(c)};
        tick();
        pio_word[20] = 1'b0;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        pio_word   = '0;
        plot_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(plot_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_clip",  32'(clip_cnt),   0);
        chk("rst_drop",  32'(drop_cnt),   0);
        chk("rst_mode",  32'(vga_mode),   0);
        chk("rst_addr",  32'(plot_addr),  0);
        reset = 1'b0;

        // single plot, latency and far-corner address in 320x240
        plot_ready = 1'b1;
        expect_plot(1'b1, 319, 239, 5);
        pio_word = {1'b1, 1'b1, 9'd319, 8'd239, 3'd5};
        tick();
        chk("valid_after_edge0", 32'(plot_valid), 0);
        pio_word[20] = 1'b0;
        tick();
        chk("valid_after_edge1", 32'(plot_valid),  1);
        chk("single_addr",       32'(plot_addr),   76799);
        chk("single_colour",     32'(plot_colour), 5);
        tick();
        chk("single_valid_off",  32'(plot_valid), 0);
        chk("single_count",      32'(fifo_count), 0);

        // clipping in 160x120
        plot(1'b0, 160, 10, 1);
        repeat (3) tick();
        chk("clip_cnt_1", 32'(clip_cnt), 1);
        plot(1'b0, 159, 119, 2);
        repeat (3) tick();
        chk("clip_edge_drained", q.size(), 0);

        // writeEn held high yields one request
        p0 = n_pops;
        expect_plot(1'b0, 10, 20, 3);
        pio_word = {1'b0, 1'b1, 9'd10, 8'd20, 3'd3};
        repeat (20) tick();
        pio_word[20] = 1'b0;
        repeat (2) tick();
        chk("level_one_plot", n_pops - p0, 1);

        // overflow with the adapter stalled
        plot_ready = 1'b0;
        for (int i = 0; i < 10; i++) plot(1'b0, i, 0, i % 8);
        repeat (2) tick();
        chk("ovf_count", 32'(fifo_count), 8);
        chk("ovf_drop",  32'(drop_cnt),   exp_drop);
        chk("ovf_valid", 32'(plot_valid), 1);
        plot_ready = 1'b1;
        repeat (10) tick();
        chk("ovf_drained_valid", 32'(plot_valid), 0);
        chk("ovf_drained_q",     q.size(),        0);

        // mode change flushes old entries, keeps the simultaneous request
        plot_ready = 1'b0;
        for (int i = 0; i < 3; i++) plot(1'b0, i + 1, 5, 1);
        tick();
        chk("flush_pre_count", 32'(fifo_count), 3);
        plot(1'b1, 300, 200, 6);
        chk("flush_count", 32'(fifo_count), 1);
        chk("flush_mode",  32'(vga_mode),   1);
        chk("flush_addr",  32'(plot_addr),  64300);
        plot_ready = 1'b1;
        repeat (3) tick();
        chk("flush_clip_kept", 32'(clip_cnt), exp_clip);
        chk("flush_drop_kept", 32'(drop_cnt), exp_drop);

        // reset with entries queued
        plot_ready = 1'b0;
        for (int i = 0; i < 5; i++) plot(1'b1, i, i, 7);
        tick();
        chk("rq_count", 32'(fifo_count), 5);
        reset    = 1'b1;
        pio_word = '0;
        #1;
        chk("rq_valid", 32'(plot_valid), 0);
        chk("rq_count0", 32'(fifo_count), 0);
        chk("rq_addr",  32'(plot_addr),  0);
        chk("rq_clip",  32'(clip_cnt),   0);
        chk("rq_drop",  32'(drop_cnt),   0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        q.delete();
        cur_mode   = 1'b0;
        plot_ready = 1'b1;
        p0 = n_pops;
        repeat (6) tick();
        chk("rq_no_plot", n_pops - p0, 0);
        plot(1'b0, 1, 1, 1);
        repeat (3) tick();
        chk("rq_fresh_plot", n_pops - p0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
